// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 constants, polarity encoding,
// control-bit bundle carried through the renderer-latency delay line.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE  = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_ACTIVE  = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;
  localparam int unsigned VGA_CLK_DIV   = 4;
  localparam int unsigned VGA_PIPE      = 2;
  localparam int unsigned VGA_MAX_PIPE  = 8;
  localparam int unsigned VGA_MAX_TOTAL = 1024;

  typedef enum logic {
    POL_ACTIVE_LOW  = 1'b0,
    POL_ACTIVE_HIGH = 1'b1
  } sync_pol_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic video;
  } sync_bits_t;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register aligning hsync/vsync/video_on with renderer colour.
// PIPE=0 degenerates to a wire.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int unsigned PIPE = VGA_PIPE
) (
  input  logic       clk_nexys,
  input  logic       reset,
  input  logic       tick,
  input  sync_bits_t d,
  output sync_bits_t q
);

  if (PIPE == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk_nexys, reset, tick};
    assign q = d;
  end else begin : g_pipe
    sync_bits_t stage [PIPE];

    always_ff @(posedge clk_nexys) begin
      if (reset) begin
        for (int unsigned i = 0; i < PIPE; i++) stage[i] <= '0;
      end else if (tick) begin
        stage[0] <= d;
        for (int unsigned i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[PIPE-1];
  end

endmodule

// File: rtl/vga_ctrl_param.sv
// Parametrised VGA raster controller: pixel divider, h/v counters, sync/blank
// generation and renderer-latency compensation ahead of the pin registers.
module vga_ctrl_param
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter logic        HS_POL   = POL_ACTIVE_LOW,
  parameter logic        VS_POL   = POL_ACTIVE_LOW,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned PIPE     = VGA_PIPE,
  parameter logic [RGB_W-1:0] RESET_COLOR = '1
) (
  input  logic             clk_nexys,
  input  logic             reset,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_tick,
  output logic [9:0]       pixel_x,
  output logic [9:0]       pixel_y,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] color_salida
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = clog2_min1(CLK_DIV);

  if (CLK_DIV < 1 || PIPE > VGA_MAX_PIPE || H_TOTAL > VGA_MAX_TOTAL || V_TOTAL > VGA_MAX_TOTAL)
  begin : g_bad_params
    $error("vga_ctrl_param: illegal CLK_DIV, PIPE or frame size");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap_x;
  logic             wrap_y;
  sync_bits_t       ctrl_raw;
  sync_bits_t       ctrl_dly;

  always_ff @(posedge clk_nexys) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Gated by reset so CLK_DIV=1 still shows no tick while reset is held.
  assign pix_tick    = ~reset & (div_cnt == DIV_LAST);
  assign wrap_x      = (pixel_x == H_LAST);
  assign wrap_y      = (pixel_y == V_LAST);
  assign line_start  = pix_tick & wrap_x;
  assign frame_start = line_start & wrap_y;

  always_ff @(posedge clk_nexys) begin
    if (reset) begin
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (pix_tick) begin
      if (wrap_x) begin
        pixel_x <= '0;
        pixel_y <= wrap_y ? '0 : pixel_y + 10'd1;
      end else begin
        pixel_x <= pixel_x + 10'd1;
      end
    end
  end

  assign video_on       = (pixel_x < H_VIS) && (pixel_y < V_VIS);
  assign ctrl_raw.hs    = (pixel_x >= HS_START) && (pixel_x < HS_END);
  assign ctrl_raw.vs    = (pixel_y >= VS_START) && (pixel_y < VS_END);
  assign ctrl_raw.video = video_on;

  vga_sync_delay #(
    .PIPE (PIPE)
  ) u_sync_delay (
    .clk_nexys (clk_nexys),
    .reset     (reset),
    .tick      (pix_tick),
    .d         (ctrl_raw),
    .q         (ctrl_dly)
  );

  always_ff @(posedge clk_nexys) begin
    if (reset) begin
      hsync        <= ~HS_POL;
      vsync        <= ~VS_POL;
      color_salida <= RESET_COLOR;
    end else if (pix_tick) begin
      hsync        <= ~(ctrl_dly.hs ^ HS_POL);
      vsync        <= ~(ctrl_dly.vs ^ VS_POL);
      color_salida <= ctrl_dly.video ? rgb_in : '0;
    end
  end

endmodule
